// File: rtl/ice_mem_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
// The owner enum records which port a pending read response belongs to.
package ice_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int unsigned WORD_BYTES = 4;

  // A word access is in range when its last byte still falls inside memory.
  // The extra bit keeps addresses near 2^32 from wrapping into range.
  function automatic logic in_range(input logic [31:0] addr, input logic [32:0] last_byte);
    return ({1'b0, addr} + 33'd3) <= last_byte;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface memory_arbiter_if;

  logic        iwFetchReq;
  logic [31:0] iwFetchAddr;
  logic        owFetchGnt;
  logic        orFetchRvalid;
  logic        orFetchErr;
  logic [31:0] owFetchRdata;

  logic        iwDataReq;
  logic [3:0]  iwDataWstrb;
  logic [31:0] iwDataAddr;
  logic [31:0] iwDataWdata;
  logic        owDataGnt;
  logic        orDataRvalid;
  logic        orDataErr;
  logic [31:0] owDataRdata;

  logic [31:0] owMemReadAddr;
  logic [31:0] owMemWriteAddr;
  logic [31:0] owMemWriteData;
  logic [3:0]  owMemWstrb;
  logic [31:0] iwMemReadData;

  modport slave (
    input  iwFetchReq, iwFetchAddr,
    input  iwDataReq, iwDataWstrb, iwDataAddr, iwDataWdata,
    input  iwMemReadData,
    output owFetchGnt, orFetchRvalid, orFetchErr, owFetchRdata,
    output owDataGnt, orDataRvalid, orDataErr, owDataRdata,
    output owMemReadAddr, owMemWriteAddr, owMemWriteData, owMemWstrb
  );

  modport master (
    output iwFetchReq, iwFetchAddr,
    output iwDataReq, iwDataWstrb, iwDataAddr, iwDataWdata,
    output iwMemReadData,
    input  owFetchGnt, orFetchRvalid, orFetchErr, owFetchRdata,
    input  owDataGnt, orDataRvalid, orDataErr, owDataRdata,
    input  owMemReadAddr, owMemWriteAddr, owMemWriteData, owMemWstrb
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive conflicts won by the priority port and raises owYield
// once the limit is reached so the other port gets the next conflict.
module arb_starve_counter
  import ice_mem_pkg::*;
#(
  parameter logic [3:0] pStarveLimit = 4'd4
) (
  input  logic iwClk,
  input  logic iwnRst,
  input  logic iwPrioWin,
  output logic owYield
);

  logic [3:0] r_streak;
  logic [3:0] w_streak_next;

  assign owYield = (r_streak == pStarveLimit);

  always_comb begin
    w_streak_next = 4'd0;
    if (iwPrioWin) begin
      w_streak_next = owYield ? r_streak : r_streak + 4'd1;
    end
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      r_streak <= 4'd0;
    end else begin
      r_streak <= w_streak_next;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port-per-direction memory between instruction fetch and
// load/store: one access per cycle, responses routed back one cycle later.
module memory_arbiter
  import ice_mem_pkg::*;
#(
  parameter int unsigned pWords        = 32'd128,
  parameter logic        pDataPriority = 1'b1,
  parameter logic [3:0]  pStarveLimit  = 4'd4
) (
  input  logic             iwClk,
  input  logic             iwnRst,
  memory_arbiter_if.slave  bus
);

  localparam logic [32:0] LAST_BYTE = 33'(pWords * WORD_BYTES) - 33'd1;

  logic        w_conflict;
  logic        w_yield;
  logic        w_data_wins;
  logic        w_data_gnt;
  logic        w_fetch_gnt;
  logic        w_prio_win;
  logic [31:0] w_gnt_addr;
  logic        w_in_range;
  logic        w_store;

  owner_e      r_owner;
  logic        r_err;
  logic        r_store;
  owner_e      w_owner_next;
  logic        w_err_next;
  logic        w_store_next;

  // Grant: the priority port wins conflicts unless its streak hit the limit.
  assign w_conflict  = bus.iwFetchReq & bus.iwDataReq;
  assign w_data_wins = pDataPriority ^ w_yield;
  assign w_data_gnt  = bus.iwDataReq & (~bus.iwFetchReq | w_data_wins);
  assign w_fetch_gnt = bus.iwFetchReq & ~w_data_gnt;
  assign w_prio_win  = w_conflict & (pDataPriority ? w_data_gnt : w_fetch_gnt);

  arb_starve_counter #(
    .pStarveLimit (pStarveLimit)
  ) u_starve (
    .iwClk     (iwClk),
    .iwnRst    (iwnRst),
    .iwPrioWin (w_prio_win),
    .owYield   (w_yield)
  );

  assign bus.owFetchGnt = w_fetch_gnt;
  assign bus.owDataGnt  = w_data_gnt;

  assign w_gnt_addr = w_data_gnt  ? bus.iwDataAddr  :
                      w_fetch_gnt ? bus.iwFetchAddr : 32'd0;
  assign w_in_range = in_range(w_gnt_addr, LAST_BYTE);
  assign w_store    = w_data_gnt & (|bus.iwDataWstrb);

  // Out-of-range stores are still accepted but must never reach the array.
  assign bus.owMemReadAddr  = w_gnt_addr;
  assign bus.owMemWriteAddr = w_store ? bus.iwDataAddr  : 32'd0;
  assign bus.owMemWriteData = w_store ? bus.iwDataWdata : 32'd0;
  assign bus.owMemWstrb     = (w_store & w_in_range) ? bus.iwDataWstrb : 4'd0;

  always_comb begin
    w_owner_next = OWN_NONE;
    w_err_next   = 1'b0;
    w_store_next = 1'b0;
    if (w_data_gnt) begin
      w_owner_next = OWN_DATA;
      w_err_next   = ~w_in_range;
      w_store_next = w_store;
    end else if (w_fetch_gnt) begin
      w_owner_next = OWN_FETCH;
      w_err_next   = ~w_in_range;
    end
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_store <= 1'b0;
    end else begin
      r_owner <= w_owner_next;
      r_err   <= w_err_next;
      r_store <= w_store_next;
    end
  end

  // Memory read data lines up with the registered owner one cycle after grant.
  assign bus.orFetchRvalid = (r_owner == OWN_FETCH);
  assign bus.orFetchErr    = (r_owner == OWN_FETCH) & r_err;
  assign bus.owFetchRdata  = ((r_owner == OWN_FETCH) && !r_err) ? bus.iwMemReadData : 32'd0;

  assign bus.orDataRvalid  = (r_owner == OWN_DATA);
  assign bus.orDataErr     = (r_owner == OWN_DATA) & r_err;
  assign bus.owDataRdata   = ((r_owner == OWN_DATA) && !r_err && !r_store) ?
                             bus.iwMemReadData : 32'd0;

endmodule
